// File: rtl/vecmat_collect.sv
// Collects delayed adder-tree sums for one row, packs them into buffer words and writes them out.
// Optional: define VECMAT_COLLECT_RELU_EN to clamp negative sums to zero before packing.
module vecmat_collect #(
    parameter int DATA_WIDTH    = 16,
    parameter int WORDS_PER_LOC = 4,
    parameter int NUM_RESULTS   = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int ADD_LATENCY   = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH-1:0]               sum_in,
    output logic                                wr_en,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [DATA_WIDTH*WORDS_PER_LOC-1:0] wr_data,
    output logic                                busy,
    output logic                                done
);

    localparam int LW = (WORDS_PER_LOC > 1) ? $clog2(WORDS_PER_LOC) : 1;
    localparam int RW = $clog2(NUM_RESULTS + 1);
    localparam int PW = DATA_WIDTH * WORDS_PER_LOC;
    localparam logic [LW-1:0] LANE_LAST = LW'(WORDS_PER_LOC - 1);
    localparam logic [RW-1:0] RES_LAST  = RW'(NUM_RESULTS - 1);
    localparam logic [RW-1:0] RES_MAX   = RW'(NUM_RESULTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADD_LATENCY-1:0] vsr_q, vsr_d;
    logic [PW-1:0]          lane_q, lane_d;
    logic [LW-1:0]          lane_cnt_q, lane_cnt_d;
    logic [RW-1:0]          res_cnt_q, res_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [PW-1:0]          wr_data_q, wr_data_d;
    logic [PW-1:0]          pack_s;
    logic                   v_d_s;

    function automatic logic [DATA_WIDTH-1:0] relu_f(input logic [DATA_WIDTH-1:0] s);
`ifdef VECMAT_COLLECT_RELU_EN
        if (s[DATA_WIDTH-1]) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return s;
        end
`else
        return s;
`endif
    endfunction

    assign v_d_s = vsr_q[ADD_LATENCY-1];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            vsr_q      <= {ADD_LATENCY{1'b0}};
            lane_q     <= {PW{1'b0}};
            lane_cnt_q <= {LW{1'b0}};
            res_cnt_q  <= {RW{1'b0}};
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_data_q  <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            vsr_q      <= vsr_d;
            lane_q     <= lane_d;
            lane_cnt_q <= lane_cnt_d;
            res_cnt_q  <= res_cnt_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state logic: DONE follows the write carrying the last sum of the row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (wr_en_q && (res_cnt_q == RES_MAX)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_COLLECT: busy = 1'b1;
            ST_DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Lane packing: the incoming sum is merged into the lane selected by lane_cnt_q.
    always_comb begin
        pack_s = lane_q;
        for (int i = 0; i < WORDS_PER_LOC; i++) begin
            if (lane_cnt_q == i[LW-1:0]) begin
                pack_s[i*DATA_WIDTH +: DATA_WIDTH] = relu_f(sum_in);
            end else begin
                pack_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Capture, write-out and address sequencing.
    always_comb begin
        vsr_d      = vsr_q << 1;
        vsr_d[0]   = in_valid && (state_q == ST_COLLECT);
        lane_d     = lane_q;
        lane_cnt_d = lane_cnt_q;
        res_cnt_d  = res_cnt_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if ((state_q == ST_IDLE) && start) begin
            // Drop valids still travelling from the previous row.
            vsr_d      = {ADD_LATENCY{1'b0}};
            addr_d     = base_addr;
            lane_d     = {PW{1'b0}};
            lane_cnt_d = {LW{1'b0}};
            res_cnt_d  = {RW{1'b0}};
        end else if ((state_q == ST_COLLECT) && v_d_s && (res_cnt_q < RES_MAX)) begin
            res_cnt_d = res_cnt_q + 1'b1;
            if ((lane_cnt_q == LANE_LAST) || (res_cnt_q == RES_LAST)) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = pack_s;
                addr_d     = addr_q + 1'b1;
                lane_d     = {PW{1'b0}};
                lane_cnt_d = {LW{1'b0}};
            end else begin
                lane_d     = pack_s;
                lane_cnt_d = lane_cnt_q + 1'b1;
            end
        end else begin
            lane_d = lane_q;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_vecmat_collect.sv
// Directed bench for vecmat_collect: a default instance and a NUM_RESULTS=6 instance.
module tb_vecmat_collect;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, start, start6, in_valid;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] sum_src, sum_p1, sum_in;
    logic          wr_en, busy, done, wr_en6, busy6, done6;
    logic [AW-1:0] wr_addr, wr_addr6;
    logic [63:0]   wr_data, wr_data6;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int nw = 0, ndone = 0, done_cyc = 0;
    int nw6 = 0, ndone6 = 0, done_cyc6 = 0;
    logic [AW-1:0] waddr [0:15];
    logic [63:0]   wdata [0:15];
    int            wcyc  [0:15];
    logic [AW-1:0] waddr6 [0:3];
    logic [63:0]   wdata6 [0:3];
    int            wcyc6  [0:3];

    always #5 clk = ~clk;

    vecmat_collect dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .sum_in(sum_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    vecmat_collect #(.NUM_RESULTS(6)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .base_addr(base_addr),
        .in_valid(in_valid), .sum_in(sum_in), .wr_en(wr_en6), .wr_addr(wr_addr6),
        .wr_data(wr_data6), .busy(busy6), .done(done6)
    );

    // Two-stage adder-tree model: sum_in lags in_valid by ADD_LATENCY cycles.
    always @(posedge clk) begin
        sum_p1 <= sum_src;
        sum_in <= sum_p1;
    end

    // Write/done logger, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (wr_en === 1'b1) begin
            if (nw < 16) begin
                waddr[nw] = wr_addr;
                wdata[nw] = wr_data;
                wcyc[nw]  = cyc;
            end
            nw = nw + 1;
        end
        if (done === 1'b1) begin
            done_cyc = cyc;
            ndone    = ndone + 1;
        end
        if (wr_en6 === 1'b1) begin
            if (nw6 < 4) begin
                waddr6[nw6] = wr_addr6;
                wdata6[nw6] = wr_data6;
                wcyc6[nw6]  = cyc;
            end
            nw6 = nw6 + 1;
        end
        if (done6 === 1'b1) begin
            done_cyc6 = cyc;
            ndone6    = ndone6 + 1;
        end
    end

    function automatic logic [63:0] exp_word(input int first);
        return {16'(first + 3), 16'(first + 2), 16'(first + 1), 16'(first)};
    endfunction

    task automatic clear_log;
        nw = 0; ndone = 0; nw6 = 0; ndone6 = 0;
    endtask

    task automatic begin_row(input logic [AW-1:0] b, input logic use6);
        if (use6) start6 = 1'b1; else start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0; start6 = 1'b0;
        base_addr = 4'hA;
    endtask

    task automatic send(input logic [DW-1:0] s, input logic gap);
        in_valid = 1'b1;
        sum_src  = s;
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            sum_src  = 16'hDEAD;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input logic use6, input string nm);
        int k = 0;
        in_valid = 1'b0;
        while (((use6 ? ndone6 : ndone) < 1) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if ((use6 ? ndone6 : ndone) < 1) begin
            fails++;
            $display("FAIL %s_done_timeout: got no done pulse, required one within 300 cycles", nm);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1; sum_src = 16'h5555; start = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({wr_en, wr_addr, wr_data, busy, done} !== {1'b0, 4'h0, 64'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b, required all 0",
                     wr_en, wr_addr, wr_data, busy, done);
        end
        tests++;
        if ({wr_en6, wr_addr6, wr_data6, busy6, done6} !== {1'b0, 4'h0, 64'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs6: got en=%b addr=%h data=%h busy=%b done=%b, required all 0",
                     wr_en6, wr_addr6, wr_data6, busy6, done6);
        end
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        clear_log();
        begin_row(4'd0, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        for (int i = 1; i <= 32; i++) send(16'(i), 1'b0);
        send(16'hBEEF, 1'b0);
        send(16'hBEEF, 1'b0);
        wait_done(1'b0, "basic");
        tests++;
        if (nw !== 8) begin
            fails++;
            $display("FAIL basic_write_count: got %0d, required 8", nw);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (waddr[k] !== 4'(k) || wdata[k] !== exp_word(4 * k + 1)) begin
                fails++;
                $display("FAIL basic_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                         k, waddr[k], wdata[k], 4'(k), exp_word(4 * k + 1));
            end
        end
        tests++;
        if (done_cyc !== wcyc[7] + 1 || ndone !== 1) begin
            fails++;
            $display("FAIL basic_done_timing: got done at %0d (x%0d), required at %0d once",
                     done_cyc, ndone, wcyc[7] + 1);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_after: got busy=%b done=%b en=%b, required 0 0 0", busy, done, wr_en);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a [0:7];
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        clear_log();
        begin_row(4'd14, 1'b0);
        for (int i = 1; i <= 32; i++) send(16'(i + 100), 1'b0);
        wait_done(1'b0, "wrap");
        tests++;
        if (nw !== 8) begin
            fails++;
            $display("FAIL wrap_write_count: got %0d, required 8", nw);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (waddr[k] !== exp_a[k]) begin
                fails++;
                $display("FAIL wrap_addr%0d: got %0d, required %0d", k, waddr[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_partial;
        clear_log();
        begin_row(4'd0, 1'b1);
        for (int i = 0; i < 6; i++) send(16'h0011 + 16'(i), 1'b0);
        wait_done(1'b1, "partial");
        tests++;
        if (nw6 !== 2 || nw !== 0) begin
            fails++;
            $display("FAIL partial_write_count: got %0d (main %0d), required 2 (main 0)", nw6, nw);
        end
        tests++;
        if (wdata6[0] !== 64'h0014_0013_0012_0011 || waddr6[0] !== 4'd0) begin
            fails++;
            $display("FAIL partial_word0: got addr=%h data=%h, required 0 0014001300120011", waddr6[0], wdata6[0]);
        end
        tests++;
        if (wdata6[1] !== 64'h0000_0000_0016_0015 || waddr6[1] !== 4'd1) begin
            fails++;
            $display("FAIL partial_word1: got addr=%h data=%h, required 1 0000000000160015", waddr6[1], wdata6[1]);
        end
        tests++;
        if (done_cyc6 !== wcyc6[1] + 1) begin
            fails++;
            $display("FAIL partial_done_timing: got %0d, required %0d", done_cyc6, wcyc6[1] + 1);
        end
    endtask

    task automatic test_reset_mid;
        int nw_before;
        clear_log();
        begin_row(4'd3, 1'b0);
        for (int i = 1; i <= 12; i++) send(16'(i), 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        nw_before = nw;
        tests++;
        if (nw_before !== 2) begin
            fails++;
            $display("FAIL resetmid_writes_before: got %0d, required 2", nw_before);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (nw !== 2) begin
            fails++;
            $display("FAIL resetmid_no_write_after: got %0d writes, required 2", nw);
        end
        tests++;
        if ({wr_en, wr_addr, wr_data, busy, done} !== {1'b0, 4'h0, 64'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL resetmid_outputs: got en=%b addr=%h data=%h busy=%b done=%b, required all 0",
                     wr_en, wr_addr, wr_data, busy, done);
        end
        clear_log();
        begin_row(4'd3, 1'b0);
        for (int i = 1; i <= 32; i++) send(16'(i), 1'b0);
        wait_done(1'b0, "resetmid");
        tests++;
        if (nw !== 8 || waddr[0] !== 4'd3 || waddr[7] !== 4'd10 || wdata[0] !== exp_word(1)) begin
            fails++;
            $display("FAIL resetmid_restart: got n=%0d a0=%0d a7=%0d d0=%h, required 8 3 10 %h",
                     nw, waddr[0], waddr[7], wdata[0], exp_word(1));
        end
    endtask

    task automatic test_gapped_idle;
        clear_log();
        in_valid = 1'b1; sum_src = 16'h7777;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_valid_busy: got %b, required 0", busy);
        end
        sum_src = 16'h6666;
        begin_row(4'd5, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                start = 1'b1;
                base_addr = 4'd9;
            end
            send(16'(i), 1'b1);
            start = 1'b0;
        end
        wait_done(1'b0, "gapped");
        tests++;
        if (nw !== 8 || ndone !== 1) begin
            fails++;
            $display("FAIL gapped_counts: got writes=%0d dones=%0d, required 8 1", nw, ndone);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (waddr[k] !== 4'(k + 5) || wdata[k] !== exp_word(4 * k + 1)) begin
                fails++;
                $display("FAIL gapped_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                         k, waddr[k], wdata[k], 4'(k + 5), exp_word(4 * k + 1));
            end
        end
    endtask

    task automatic test_relu;
        logic [63:0] exp0;
`ifdef VECMAT_COLLECT_RELU_EN
        exp0 = 64'h7FFF_0000_0005_0000;
`else
        exp0 = 64'h7FFF_8000_0005_FFF0;
`endif
        clear_log();
        begin_row(4'd0, 1'b0);
        send(16'hFFF0, 1'b0);
        send(16'h0005, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h7FFF, 1'b0);
        for (int i = 0; i < 28; i++) send(16'h0000, 1'b0);
        wait_done(1'b0, "relu");
        tests++;
        if (wdata[0] !== exp0 || wdata[1] !== 64'h0) begin
            fails++;
            $display("FAIL relu_word: got %h / %h, required %h / 0", wdata[0], wdata[1], exp0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start6 = 1'b0; in_valid = 1'b0;
        base_addr = 4'h0; sum_src = 16'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_partial();
        test_reset_mid();
        test_gapped_idle();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000, required finish earlier");
        $fatal(1, "timeout");
    end

endmodule
